// File: rtl/p_i_cache_ctrl_nway.sv
// Instruction-cache control FSM: hit/miss handling, line fill with replay, tree-PLRU
// victim selection and whole-cache invalidate sweep, for NUM_WAYS ways.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no request seen since reset; same outputs as S_HIT
// S_HIT    | serving lookups; hits respond in the same cycle
// S_MISS   | line fill outstanding on pmem, held address selected
// S_REPLAY | one-cycle re-lookup of the held address after the fill
// S_FLUSH  | invalidate sweep over all sets, one set per cycle
module p_i_cache_ctrl_nway #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    output logic                mem_resp,
    output logic                pmem_read,
    input  logic                pmem_resp,
    input  logic [NUM_WAYS-1:0] hit_vec,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-2:0] plru_in,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic [NUM_WAYS-1:0] valid_load,
    output logic                valid_datain,
    output logic [NUM_WAYS-1:0] tag_load,
    output logic [NUM_WAYS-1:0] data_we,
    output logic                plru_load,
    output logic [NUM_WAYS-2:0] plru_datain,
    output logic                addr_sel,
    output logic                flush_mode,
    output logic [SET_W-1:0]    flush_set
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HIT    = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_REPLAY = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic                flush_pend_q, flush_pend_d;
    logic [SET_W-1:0]    cnt_q, cnt_d;
    logic                refetch_q, refetch_d;

    logic [WAY_W-1:0]    hit_way, inv_way, victim;
    logic                any_inv, any_hit;
    logic [NUM_WAYS-1:0] victim_oh;
    logic [NUM_WAYS-2:0] plru_upd;

    // Walk root to leaf, pointing every on-path node away from the accessed way.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] p,
                                                       input logic [WAY_W-1:0] way);
        logic [NUM_WAYS-2:0] r;
        logic [WAY_W-1:0]    sh;
        logic                b;
        int                  node;
        r    = p;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            sh = way >> (WAY_W - 1 - l);
            b  = sh[0];
            r[WAY_W'(node)] = b;
            node = 2 * node + 1 + int'(b);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] p);
        logic [WAY_W-1:0] v;
        logic             b;
        int               node;
        v    = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b    = ~p[WAY_W'(node)];
            v    = WAY_W'({v, b});
            node = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WAY_W'(i);
            if (!valid_vec[i]) begin
                inv_way = WAY_W'(i);
                any_inv = 1'b1;
            end
        end
    end

    assign any_hit   = |hit_vec;
    assign victim    = any_inv ? inv_way : plru_victim(plru_in);
    assign victim_oh = {{(NUM_WAYS-1){1'b0}}, 1'b1} << victim;
    assign plru_upd  = plru_touch(plru_in, hit_way);

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q | flush_req;
        cnt_d        = cnt_q;
        refetch_d    = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        valid_load   = '0;
        valid_datain = 1'b0;
        tag_load     = '0;
        data_we      = '0;
        plru_load    = 1'b0;
        plru_datain  = plru_upd;
        addr_sel     = 1'b0;
        flush_mode   = 1'b0;
        flush_set    = '0;
        case (state_q)
            S_IDLE, S_HIT: begin
                // First cycle after a sweep re-presents the stalled address; its
                // lookup result is only valid next cycle, so neither respond nor miss.
                addr_sel = refetch_q;
                if (!refetch_q && mem_read && any_hit) begin
                    mem_resp  = 1'b1;
                    plru_load = 1'b1;
                end
                if (!refetch_q && mem_read && !any_hit) state_d = S_MISS;
                else if (flush_pend_q)                  state_d = S_FLUSH;
                else if (mem_read || refetch_q)         state_d = S_HIT;
            end
            S_MISS: begin
                addr_sel  = 1'b1;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    tag_load     = victim_oh;
                    valid_load   = victim_oh;
                    valid_datain = 1'b1;
                    data_we      = victim_oh;
                    state_d      = S_REPLAY;
                end
            end
            S_REPLAY: begin
                addr_sel = 1'b1;
                state_d  = S_HIT;
            end
            S_FLUSH: begin
                flush_mode  = 1'b1;
                flush_set   = cnt_q;
                valid_load  = '1;
                plru_load   = 1'b1;
                plru_datain = '0;
                if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                    refetch_d    = 1'b1;
                    state_d      = S_HIT;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registers are already cleared by reset; only input-driven outputs need gating.
        if (rst) begin
            mem_resp  = 1'b0;
            plru_load = 1'b0;
        end
    end

    assign flush_busy = flush_pend_q | (state_q == S_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            refetch_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            refetch_q    <= refetch_d;
        end
    end
endmodule

// File: tb/tb_p_i_cache_ctrl_nway.sv
// Bench for p_i_cache_ctrl_nway: directed sequence with randomized set contents,
// checked against a range-splitting PLRU reference model.
module tb_p_i_cache_ctrl_nway;
    logic clk;
    logic rst;

    logic       a_mem_read, a_mem_resp, a_pmem_read, a_pmem_resp;
    logic [3:0] a_hit, a_valid;
    logic [2:0] a_plru;
    logic       a_flush_req, a_flush_busy;
    logic [3:0] a_valid_load, a_tag_load, a_data_we;
    logic       a_valid_datain, a_plru_load, a_addr_sel, a_flush_mode;
    logic [2:0] a_plru_datain, a_flush_set;

    logic       b_mem_read, b_mem_resp, b_pmem_read, b_pmem_resp;
    logic [7:0] b_hit, b_valid;
    logic [6:0] b_plru;
    logic       b_flush_req, b_flush_busy;
    logic [7:0] b_valid_load, b_tag_load, b_data_we;
    logic       b_valid_datain, b_plru_load, b_addr_sel, b_flush_mode;
    logic [6:0] b_plru_datain;
    logic [3:0] b_flush_set;

    int passed = 0;
    int total  = 0;

    p_i_cache_ctrl_nway u_a (
        .clk(clk), .rst(rst),
        .mem_read(a_mem_read), .mem_resp(a_mem_resp),
        .pmem_read(a_pmem_read), .pmem_resp(a_pmem_resp),
        .hit_vec(a_hit), .valid_vec(a_valid), .plru_in(a_plru),
        .flush_req(a_flush_req), .flush_busy(a_flush_busy),
        .valid_load(a_valid_load), .valid_datain(a_valid_datain),
        .tag_load(a_tag_load), .data_we(a_data_we),
        .plru_load(a_plru_load), .plru_datain(a_plru_datain),
        .addr_sel(a_addr_sel), .flush_mode(a_flush_mode), .flush_set(a_flush_set)
    );

    p_i_cache_ctrl_nway #(.NUM_WAYS(8), .NUM_SETS(16)) u_b (
        .clk(clk), .rst(rst),
        .mem_read(b_mem_read), .mem_resp(b_mem_resp),
        .pmem_read(b_pmem_read), .pmem_resp(b_pmem_resp),
        .hit_vec(b_hit), .valid_vec(b_valid), .plru_in(b_plru),
        .flush_req(b_flush_req), .flush_busy(b_flush_busy),
        .valid_load(b_valid_load), .valid_datain(b_valid_datain),
        .tag_load(b_tag_load), .data_we(b_data_we),
        .plru_load(b_plru_load), .plru_datain(b_plru_datain),
        .addr_sel(b_addr_sel), .flush_mode(b_flush_mode), .flush_set(b_flush_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Victim: lowest invalid way, else halve the way range following the tree bits.
    function automatic int m_victim(input int valid, input int plru, input int n);
        int lo, hi, mid, node;
        for (int i = 0; i < n; i++)
            if (((valid >> i) & 1) == 0) return i;
        lo = 0; hi = n; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (((plru >> node) & 1) == 1) begin hi = mid; node = 2 * node + 1; end
            else begin lo = mid; node = 2 * node + 2; end
        end
        return lo;
    endfunction

    function automatic int m_update(input int plru, input int way, input int n);
        int lo, hi, mid, node, p;
        lo = 0; hi = n; node = 0; p = plru;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (way < mid) begin p = p & ~(1 << node); hi = mid; node = 2 * node + 1; end
            else begin p = p | (1 << node); lo = mid; node = 2 * node + 2; end
        end
        return p;
    endfunction

    function automatic int m_lowest(input int v);
        for (int i = 0; i < 32; i++)
            if (((v >> i) & 1) == 1) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vic, lat, h, p;
        rst = 1'b1;
        a_mem_read = 1'b1; a_hit = 4'b0001; a_valid = 4'hF; a_plru = '0;
        a_pmem_resp = 1'b0; a_flush_req = 1'b0;
        b_mem_read = 1'b0; b_hit = '0; b_valid = '0; b_plru = '0;
        b_pmem_resp = 1'b0; b_flush_req = 1'b0;
        #3;
        chk("rst_mem_resp", a_mem_resp, 0);
        chk("rst_plru_load", a_plru_load, 0);
        chk("rst_pmem_read", a_pmem_read, 0);
        chk("rst_flush_busy", a_flush_busy, 0);
        chk("rst_addr_sel", a_addr_sel, 0);
        chk("rst_flush_mode", a_flush_mode, 0);

        // cold miss, 5-cycle fill
        tick(); rst = 1'b0; a_hit = '0; a_valid = '0; a_plru = '0;
        #2;
        chk("cold_idle_resp", a_mem_resp, 0);
        chk("cold_idle_pmem", a_pmem_read, 0);
        for (int k = 1; k <= 5; k++) begin
            tick(); a_pmem_resp = (k == 5);
            #2;
            chk("cold_pmem_read", a_pmem_read, 1);
            chk("cold_addr_sel", a_addr_sel, 1);
            chk("cold_tag_load", a_tag_load, (k == 5) ? 1 : 0);
        end
        chk("cold_data_we", a_data_we, 1);
        chk("cold_valid_load", a_valid_load, 1);
        chk("cold_valid_datain", a_valid_datain, 1);
        chk("cold_no_plru", a_plru_load, 0);
        tick(); a_pmem_resp = 1'b0;
        #2;
        chk("replay_addr_sel", a_addr_sel, 1);
        chk("replay_resp", a_mem_resp, 0);
        chk("replay_pmem", a_pmem_read, 0);
        tick(); a_hit = 4'b0001; a_valid = 4'b0001; a_plru = 3'b111;
        #2;
        chk("post_fill_resp", a_mem_resp, 1);
        chk("post_fill_plru", a_plru_datain, m_update(7, 0, 4));
        chk("post_fill_addr_sel", a_addr_sel, 0);

        // directed hit on way 2
        tick(); a_hit = 4'b0100; a_valid = 4'hF; a_plru = 3'b000;
        #2;
        chk("hit2_plru", a_plru_datain, m_update(0, 2, 4));

        // back-to-back random hits
        for (int k = 0; k < 10; k++) begin
            tick();
            h = $urandom_range(1, 15); p = $urandom_range(0, 7);
            a_hit = 4'(h); a_plru = 3'(p);
            #2;
            chk("b2b_resp", a_mem_resp, 1);
            chk("b2b_addr_sel", a_addr_sel, 0);
            chk("b2b_plru_load", a_plru_load, 1);
            chk("b2b_plru", a_plru_datain, m_update(p, m_lowest(h), 4));
        end

        // random misses with random set contents and fill latency
        for (int it = 0; it < 8; it++) begin
            tick();
            a_mem_read = 1'b1; a_hit = '0;
            a_valid = (it % 2 == 1) ? 4'hF : 4'($urandom_range(0, 15));
            p = $urandom_range(0, 7); a_plru = 3'(p);
            vic = m_victim(int'(a_valid), p, 4);
            #2;
            chk("miss_no_resp", a_mem_resp, 0);
            lat = $urandom_range(1, 4);
            for (int k = 1; k <= lat; k++) begin
                tick();
                a_mem_read = (it == 2) ? 1'b0 : 1'b1;
                a_pmem_resp = (k == lat);
                #2;
                chk("miss_pmem_read", a_pmem_read, 1);
                chk("miss_tag_load", a_tag_load, (k == lat) ? (1 << vic) : 0);
            end
            tick(); a_pmem_resp = 1'b0; a_mem_read = 1'b1;
            #2;
            chk("miss_replay", a_addr_sel, 1);
            tick(); a_hit = 4'(1 << vic);
            #2;
            chk("miss_final_resp", a_mem_resp, 1);
        end

        // flush requested during a miss
        tick(); a_hit = '0; a_valid = '0; a_plru = '0;
        tick(); a_flush_req = 1'b1;
        tick(); a_flush_req = 1'b0;
        #2;
        chk("fmiss_busy", a_flush_busy, 1);
        chk("fmiss_pmem", a_pmem_read, 1);
        tick(); a_pmem_resp = 1'b1;
        #2;
        chk("fmiss_fill", a_tag_load, 1);
        tick(); a_pmem_resp = 1'b0;
        #2;
        chk("fmiss_replay_nofl", a_flush_mode, 0);
        tick(); a_hit = 4'b0001;
        #2;
        chk("fmiss_replay_resp", a_mem_resp, 1);
        chk("fmiss_busy2", a_flush_busy, 1);
        for (int s = 0; s < 8; s++) begin
            tick(); a_flush_req = (s == 4);
            #2;
            chk("sweep_mode", a_flush_mode, 1);
            chk("sweep_set", a_flush_set, s);
            chk("sweep_vload", a_valid_load, 4'hF);
            chk("sweep_vdata", a_valid_datain, 0);
            chk("sweep_plru", {a_plru_load, a_plru_datain}, 4'b1000);
            chk("sweep_no_resp", a_mem_resp, 0);
            chk("sweep_busy", a_flush_busy, 1);
        end
        tick(); a_flush_req = 1'b0; a_hit = '0;
        #2;
        chk("refetch_addr_sel", a_addr_sel, 1);
        chk("refetch_mode", a_flush_mode, 0);
        chk("refetch_busy", a_flush_busy, 0);
        chk("refetch_resp", a_mem_resp, 0);
        tick();
        #2;
        chk("post_flush_addr_sel", a_addr_sel, 0);
        chk("post_flush_resp", a_mem_resp, 0);
        tick(); a_pmem_resp = 1'b1;
        #2;
        chk("post_flush_miss", a_pmem_read, 1);
        tick(); a_pmem_resp = 1'b0; a_mem_read = 1'b0;

        // reset in the middle of a sweep
        tick(); a_flush_req = 1'b1;
        tick(); a_flush_req = 1'b0;
        #2;
        chk("rsw_busy", a_flush_busy, 1);
        for (int s = 0; s < 4; s++) begin
            tick();
            #2;
            chk("rsw_set", a_flush_set, s);
        end
        #1 rst = 1'b1;
        #1;
        chk("rsw_mode", a_flush_mode, 0);
        chk("rsw_vload", a_valid_load, 0);
        chk("rsw_plru_load", a_plru_load, 0);
        chk("rsw_busy_clr", a_flush_busy, 0);
        chk("rsw_set_clr", a_flush_set, 0);
        tick(); rst = 1'b0; a_mem_read = 1'b1; a_hit = '0; a_valid = '0;
        #2;
        chk("rsw_idle_resp", a_mem_resp, 0);
        chk("rsw_idle_pmem", a_pmem_read, 0);
        tick(); a_pmem_resp = 1'b1;
        #2;
        chk("rsw_miss_pmem", a_pmem_read, 1);
        chk("rsw_miss_fill", a_tag_load, 1);
        tick(); a_pmem_resp = 1'b0;
        tick(); a_hit = 4'b0001;
        #2;
        chk("rsw_hit_resp", a_mem_resp, 1);
        tick(); a_mem_read = 1'b0;

        // 8-way victim over every PLRU pattern, then a 16-set sweep
        for (int q = 0; q < 128; q++) begin
            tick(); b_mem_read = 1'b1; b_hit = '0; b_valid = 8'hFF; b_plru = 7'(q);
            #2;
            chk("w8_miss_resp", b_mem_resp, 0);
            vic = m_victim(255, q, 8);
            tick(); b_pmem_resp = 1'b1;
            #2;
            chk("w8_victim", b_tag_load, 1 << vic);
            tick(); b_pmem_resp = 1'b0;
            tick(); b_hit = 8'(1 << vic);
            #2;
            chk("w8_hit_resp", b_mem_resp, 1);
            chk("w8_plru_upd", b_plru_datain, m_update(q, vic, 8));
        end
        tick(); b_mem_read = 1'b0; b_hit = '0; b_flush_req = 1'b1;
        tick(); b_flush_req = 1'b0;
        for (int s = 0; s < 16; s++) begin
            tick();
            #2;
            chk("w8_sweep_mode", b_flush_mode, 1);
            chk("w8_sweep_set", b_flush_set, s);
        end
        tick();
        #2;
        chk("w8_sweep_done", b_flush_mode, 0);
        chk("w8_busy_done", b_flush_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
